// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline stage of the RV32 core.
// Registers the ALU result and its companions, resolves branches/jumps,
// issues a one-cycle fetch redirect, squashes the wrong-path instruction
// seen during the redirect cycle, and hands results to MEM over valid/ready.
// Build option: define EX_SKID_BUF_EN for a two-entry skid buffer with a
// fully registered ex_ready; left undefined, a single output register is
// used and ex_ready depends combinationally on mem_ready.

module ex_mem_stage #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic [N-1:0] ex_alu_out,
    input  logic         ex_alu_zero,
    input  logic         ex_a_msb,
    input  logic         ex_b_msb,
    input  logic         ex_is_branch,
    input  logic         ex_is_jump,
    input  logic [2:0]   ex_funct3,
    input  logic [N-1:0] ex_target,
    input  logic [N-1:0] ex_pc_plus4,
    input  logic [N-1:0] ex_store_data,
    input  logic         ex_mem_read,
    input  logic         ex_mem_write,
    input  logic         ex_reg_write,
    input  logic [4:0]   ex_rd,
    input  logic         flush,
    output logic         redirect_valid,
    output logic [N-1:0] redirect_pc,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic [N-1:0] mem_result,
    output logic [N-1:0] mem_store_data,
    output logic         mem_mem_read,
    output logic         mem_mem_write,
    output logic         mem_reg_write,
    output logic [4:0]   mem_rd
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    typedef struct packed {
        logic [N-1:0] result;
        logic [N-1:0] store_data;
        logic         mem_read;
        logic         mem_write;
        logic         reg_write;
        logic [4:0]   rd;
    } payload_t;

    state_t       r_state;
    state_t       w_state_nxt;
    payload_t     r_main;
    payload_t     w_in;
    logic         r_redirect_valid;
    logic [N-1:0] r_redirect_pc;

    logic         w_accept;
    logic         w_push;
    logic         w_xfer;
    logic         w_blt;
    logic         w_cond;
    logic         w_taken;
    logic         w_redirect_nxt;
    logic         w_load_main;

`ifdef EX_SKID_BUF_EN
    payload_t     r_skid;
    logic         r_ex_ready;
    logic         w_load_skid;
    logic         w_main_from_skid;

    assign ex_ready = r_ex_ready;
`else
    assign ex_ready = (r_state == ST_EMPTY) || mem_ready || r_redirect_valid;
`endif

    // Handshakes; an instruction accepted during the redirect cycle is wrong-path and dropped
    assign w_accept       = ex_valid && ex_ready;
    assign w_xfer         = mem_valid && mem_ready;
    assign w_push         = w_accept && !r_redirect_valid && !flush;
    assign w_redirect_nxt = w_push && w_taken;

    // Branch condition from ALU flags; BLT uses operand signs to survive SUB overflow
    always_comb begin
        w_blt  = (ex_a_msb != ex_b_msb) ? ex_a_msb : ex_alu_out[N-1];
        w_cond = 1'b0;
        case (ex_funct3)
            3'b000:  w_cond = ex_alu_zero;
            3'b001:  w_cond = !ex_alu_zero;
            3'b100:  w_cond = w_blt;
            3'b101:  w_cond = !w_blt;
            3'b110:  w_cond = ex_alu_out[N-1];
            3'b111:  w_cond = !ex_alu_out[N-1];
            default: w_cond = 1'b0;
        endcase
        w_taken = ex_is_jump || (ex_is_branch && w_cond);
    end

    // Assemble the incoming MEM payload; jumps write the link value
    always_comb begin
        w_in            = '0;
        w_in.result     = ex_is_jump ? ex_pc_plus4 : ex_alu_out;
        w_in.store_data = ex_store_data;
        w_in.mem_read   = ex_mem_read;
        w_in.mem_write  = ex_mem_write;
        w_in.reg_write  = ex_reg_write;
        w_in.rd         = ex_rd;
    end

    // Output buffer next-state and register load selects
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
`ifdef EX_SKID_BUF_EN
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_xfer) begin
                    w_load_main = 1'b1;
                end
`ifdef EX_SKID_BUF_EN
                else if (w_push) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_TWO;
                end
`endif
                else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
`ifdef EX_SKID_BUF_EN
            ST_TWO: begin
                if (w_xfer) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
`endif
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
`ifdef EX_SKID_BUF_EN
            w_main_from_skid = 1'b0;
`endif
        end
    end

    // Buffer state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Payload registers; MEM only ever sees the main register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_main <= '0;
`ifdef EX_SKID_BUF_EN
            r_skid <= '0;
`endif
        end else begin
            if (w_load_main) r_main <= w_in;
`ifdef EX_SKID_BUF_EN
            else if (w_main_from_skid) r_main <= r_skid;
            if (w_load_skid) r_skid <= w_in;
`endif
        end
    end

`ifdef EX_SKID_BUF_EN
    // Registered ready: open unless full, but always open in the squash cycle
    always_ff @(posedge clock) begin
        if (reset) r_ex_ready <= 1'b1;
        else       r_ex_ready <= (w_state_nxt != ST_TWO) || w_redirect_nxt;
    end
`endif

    // One-cycle fetch redirect for an accepted taken branch or jump
    always_ff @(posedge clock) begin
        if (reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redirect_nxt;
            if (w_redirect_nxt) r_redirect_pc <= ex_target;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign mem_valid      = (r_state != ST_EMPTY);
    assign mem_result     = r_main.result;
    assign mem_store_data = r_main.store_data;
    assign mem_mem_read   = r_main.mem_read;
    assign mem_mem_write  = r_main.mem_write;
    assign mem_reg_write  = r_main.reg_write;
    assign mem_rd         = r_main.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios plus randomized traffic,
// checked against a transaction-level model (a FIFO of expected MEM ops and
// an expected pending redirect). Follows EX_SKID_BUF_EN like the design.

module tb_ex_mem_stage;

    localparam int unsigned N = 32;

    typedef struct {
        logic [N-1:0] alu;
        logic         zero;
        logic         amsb;
        logic         bmsb;
        logic         br;
        logic         jmp;
        logic [2:0]   f3;
        logic [N-1:0] tgt;
        logic [N-1:0] pc4;
        logic [N-1:0] sd;
        logic         mr;
        logic         mw;
        logic         rw;
        logic [4:0]   rd;
        logic         taken;
    } instr_t;

    typedef struct {
        logic [N-1:0] result;
        logic [N-1:0] sd;
        logic         mr;
        logic         mw;
        logic         rw;
        logic [4:0]   rd;
    } memop_t;

    logic         clock;
    logic         reset;
    logic         ex_valid;
    logic         ex_ready;
    logic [N-1:0] ex_alu_out;
    logic         ex_alu_zero;
    logic         ex_a_msb;
    logic         ex_b_msb;
    logic         ex_is_branch;
    logic         ex_is_jump;
    logic [2:0]   ex_funct3;
    logic [N-1:0] ex_target;
    logic [N-1:0] ex_pc_plus4;
    logic [N-1:0] ex_store_data;
    logic         ex_mem_read;
    logic         ex_mem_write;
    logic         ex_reg_write;
    logic [4:0]   ex_rd;
    logic         flush;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         mem_valid;
    logic         mem_ready;
    logic [N-1:0] mem_result;
    logic [N-1:0] mem_store_data;
    logic         mem_mem_read;
    logic         mem_mem_write;
    logic         mem_reg_write;
    logic [4:0]   mem_rd;

    ex_mem_stage #(.N(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_out     (ex_alu_out),
        .ex_alu_zero    (ex_alu_zero),
        .ex_a_msb       (ex_a_msb),
        .ex_b_msb       (ex_b_msb),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_funct3      (ex_funct3),
        .ex_target      (ex_target),
        .ex_pc_plus4    (ex_pc_plus4),
        .ex_store_data  (ex_store_data),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_rd          (ex_rd),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    instr_t       offer_q[$];
    memop_t       mq[$];
    logic         exp_rv;
    logic [N-1:0] exp_rpc;
    int           n_pass;
    int           n_fail;
    int           n_total;
    logic         drv_mem_ready;
    logic         drv_flush;
    logic         drv_reset;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic instr_t blank();
        instr_t i;
        i.alu = $urandom; i.zero = 1'b0; i.amsb = 1'b0; i.bmsb = 1'b0;
        i.br = 1'b0; i.jmp = 1'b0; i.f3 = 3'($urandom);
        i.tgt = $urandom; i.pc4 = $urandom; i.sd = $urandom;
        i.mr = 1'b0; i.mw = 1'b0; i.rw = 1'b0; i.rd = 5'($urandom);
        i.taken = 1'b0;
        return i;
    endfunction

    function automatic instr_t mk_alu(input logic [N-1:0] res, input logic [4:0] rd);
        instr_t i;
        i = blank();
        i.alu  = res;
        i.zero = (res == '0);
        i.mr   = ($urandom_range(0, 1) == 1);
        i.mw   = !i.mr && ($urandom_range(0, 1) == 1);
        i.rw   = !i.mw;
        i.rd   = rd;
        return i;
    endfunction

    // ALU output follows the comparison the branch needs: SUB, or SUBU with borrow in the top bit
    function automatic instr_t mk_branch(input logic [2:0] f3, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic [N-1:0] tgt);
        instr_t       i;
        logic [N-1:0] diff;
        i = blank();
        diff   = a - b;
        i.br   = 1'b1;
        i.f3   = f3;
        i.tgt  = tgt;
        i.zero = (a == b);
        i.amsb = a[N-1];
        i.bmsb = b[N-1];
        if (f3 == 3'b110 || f3 == 3'b111) i.alu = {(a < b), diff[N-2:0]};
        else                              i.alu = diff;
        case (f3)
            3'b000:  i.taken = (a == b);
            3'b001:  i.taken = (a != b);
            3'b100:  i.taken = ($signed(a) < $signed(b));
            3'b101:  i.taken = ($signed(a) >= $signed(b));
            3'b110:  i.taken = (a < b);
            3'b111:  i.taken = (a >= b);
            default: i.taken = 1'b0;
        endcase
        return i;
    endfunction

    function automatic instr_t mk_jump(input logic [N-1:0] pc4, input logic [4:0] rd,
                                       input logic [N-1:0] tgt);
        instr_t i;
        i = blank();
        i.jmp   = 1'b1;
        i.pc4   = pc4;
        i.rd    = rd;
        i.rw    = 1'b1;
        i.tgt   = tgt;
        i.taken = 1'b1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int unsigned  k;
        logic [N-1:0] a;
        logic [N-1:0] b;
        k = $urandom_range(0, 9);
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if (k < 4)      return mk_alu($urandom, 5'($urandom));
        else if (k < 9) return mk_branch(3'($urandom), a, b, $urandom);
        else            return mk_jump($urandom, 5'($urandom), $urandom);
    endfunction

    // One clock cycle: drive at negedge, check #1 later, advance the model, wait for next negedge
    task automatic cycle();
        instr_t cur;
        memop_t m;
        logic   exp_ready;
        logic   acc;
        logic   xfer;
        logic   offered;
        offered = (offer_q.size() != 0);
        cur     = offered ? offer_q[0] : blank();
        ex_valid      = offered;
        ex_alu_out    = cur.alu;
        ex_alu_zero   = cur.zero;
        ex_a_msb      = cur.amsb;
        ex_b_msb      = cur.bmsb;
        ex_is_branch  = cur.br;
        ex_is_jump    = cur.jmp;
        ex_funct3     = cur.f3;
        ex_target     = cur.tgt;
        ex_pc_plus4   = cur.pc4;
        ex_store_data = cur.sd;
        ex_mem_read   = cur.mr;
        ex_mem_write  = cur.mw;
        ex_reg_write  = cur.rw;
        ex_rd         = cur.rd;
        mem_ready     = drv_mem_ready;
        flush         = drv_flush;
        reset         = drv_reset;
        #1;
`ifdef EX_SKID_BUF_EN
        exp_ready = (mq.size() < 2) || exp_rv;
`else
        exp_ready = (mq.size() == 0) || drv_mem_ready || exp_rv;
`endif
        chk1("ex_ready", ex_ready, exp_ready);
        chk1("mem_valid", mem_valid, mq.size() != 0);
        chk1("redirect_valid", redirect_valid, exp_rv);
        if (exp_rv) chkw("redirect_pc", redirect_pc, exp_rpc);
        if (mq.size() != 0) begin
            chkw("mem_result", mem_result, mq[0].result);
            chkw("mem_store_data", mem_store_data, mq[0].sd);
            chk1("mem_mem_read", mem_mem_read, mq[0].mr);
            chk1("mem_mem_write", mem_mem_write, mq[0].mw);
            chk1("mem_reg_write", mem_reg_write, mq[0].rw);
            chkw("mem_rd", {27'b0, mem_rd}, {27'b0, mq[0].rd});
        end
        acc  = offered && exp_ready;
        xfer = (mq.size() != 0) && drv_mem_ready;
        if (drv_reset) begin
            mq.delete();
            exp_rv  = 1'b0;
            exp_rpc = '0;
        end else begin
            if (acc) void'(offer_q.pop_front());
            if (drv_flush) begin
                mq.delete();
                exp_rv = 1'b0;
            end else begin
                if (xfer) void'(mq.pop_front());
                if (acc && !exp_rv) begin
                    m.result = cur.jmp ? cur.pc4 : cur.alu;
                    m.sd     = cur.sd;
                    m.mr     = cur.mr;
                    m.mw     = cur.mw;
                    m.rw     = cur.rw;
                    m.rd     = cur.rd;
                    mq.push_back(m);
                    exp_rv = cur.taken;
                    if (cur.taken) exp_rpc = cur.tgt;
                end else begin
                    exp_rv = 1'b0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic drain();
        drv_mem_ready = 1'b1;
        drv_flush     = 1'b0;
        drv_reset     = 1'b0;
        for (int k = 0; k < 40 && (offer_q.size() != 0 || mq.size() != 0 || exp_rv); k++) cycle();
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk1({tag, "_redirect_valid"}, redirect_valid, 1'b0);
        chkw({tag, "_redirect_pc"}, redirect_pc, '0);
        chkw({tag, "_mem_result"}, mem_result, '0);
        chkw({tag, "_mem_store_data"}, mem_store_data, '0);
        chk1({tag, "_mem_mem_read"}, mem_mem_read, 1'b0);
        chk1({tag, "_mem_mem_write"}, mem_mem_write, 1'b0);
        chk1({tag, "_mem_reg_write"}, mem_reg_write, 1'b0);
        chkw({tag, "_mem_rd"}, {27'b0, mem_rd}, '0);
        chk1({tag, "_ex_ready"}, ex_ready, 1'b1);
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        exp_rv = 1'b0; exp_rpc = '0;
        drv_mem_ready = 1'b1; drv_flush = 1'b0; drv_reset = 1'b0;
        reset = 1'b1; flush = 1'b0; mem_ready = 1'b1; ex_valid = 1'b0;
        ex_alu_out = '0; ex_alu_zero = 1'b0; ex_a_msb = 1'b0; ex_b_msb = 1'b0;
        ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_funct3 = '0; ex_target = '0;
        ex_pc_plus4 = '0; ex_store_data = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_reg_write = 1'b0; ex_rd = '0;

        // Power-on reset
        repeat (2) @(negedge clock);
        check_reset_vals("por");

        // BEQ taken to 0x100; the following instruction lands in the squash cycle
        offer_q.push_back(mk_branch(3'b000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0100));
        offer_q.push_back(mk_alu(32'hAAAA_5555, 5'd7));
        cycle();
        chk1("beq_redirect_valid", redirect_valid, 1'b1);
        chkw("beq_redirect_pc", redirect_pc, 32'h0000_0100);
        cycle();
        chk1("beq_redirect_one_cycle", redirect_valid, 1'b0);
        cycle();
        cycle();

        // BLTU taken on borrow; filler is squashed; BLT overflow case not taken
        offer_q.push_back(mk_branch(3'b110, 32'h0000_0000, 32'h8000_0000, 32'h0000_0200));
        offer_q.push_back(mk_alu(32'h0000_0001, 5'd8));
        offer_q.push_back(mk_branch(3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0300));
        cycle();
        chk1("bltu_taken", redirect_valid, 1'b1);
        chkw("bltu_alu", mem_result, 32'h8000_0000);
        cycle();
        cycle();
        chk1("blt_overflow_not_taken", redirect_valid, 1'b0);
        cycle();

        // JAL: link value goes to MEM with reg_write, redirect issued
        offer_q.push_back(mk_jump(32'h0000_0044, 5'd1, 32'h0000_0400));
        cycle();
        chkw("jal_result", mem_result, 32'h0000_0044);
        chk1("jal_reg_write", mem_reg_write, 1'b1);
        chkw("jal_rd", {27'b0, mem_rd}, 32'd1);
        chk1("jal_redirect", redirect_valid, 1'b1);
        chkw("jal_redirect_pc", redirect_pc, 32'h0000_0400);
        drain();

        // MEM stall for 4 cycles with 3 back-to-back offers, then release
        drv_mem_ready = 1'b0;
        offer_q.push_back(mk_alu(32'h0000_0A0A, 5'd10));
        offer_q.push_back(mk_alu(32'h0000_0B0B, 5'd11));
        offer_q.push_back(mk_alu(32'h0000_0C0C, 5'd12));
        repeat (4) cycle();
        drain();

        // Flush while the buffer is full and the squash cycle accepts an instruction
        drv_mem_ready = 1'b0;
        offer_q.push_back(mk_alu(32'h0000_1414, 5'd20));
        offer_q.push_back(mk_jump(32'h0000_0088, 5'd21, 32'h0000_0500));
        offer_q.push_back(mk_alu(32'h0000_1616, 5'd22));
        cycle();
        cycle();
        drv_flush = 1'b1;
        cycle();
        drv_flush = 1'b0;
        chk1("flush_mem_valid", mem_valid, 1'b0);
        chk1("flush_redirect_valid", redirect_valid, 1'b0);
        drain();

        // Reset during a stall with a redirect pending
        drv_mem_ready = 1'b0;
        offer_q.push_back(mk_jump(32'h0000_009C, 5'd3, 32'h0000_0600));
        offer_q.push_back(mk_alu(32'h0000_0404, 5'd4));
        cycle();
        drv_reset = 1'b1;
        cycle();
        check_reset_vals("stall_reset");
        drv_reset = 1'b0;
        drain();

        // Randomized traffic with random backpressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            if (offer_q.size() < 2 && $urandom_range(0, 3) != 0) offer_q.push_back(rand_instr());
            drv_mem_ready = ($urandom_range(0, 3) != 0);
            drv_flush     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
